jedro_1_mem_arbiter: RTL and testbench
======================================

JEDRO_1_MEM_ARBITER -- requirements
Module: jedro_1_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width of all ports; byte-enable width is DATA_WIDTH/8.
REQ-003 Parameter MAX_DATA_STREAK, default 4, maximum consecutive data grants while the instruction port is requesting.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rstn_i  input  1  asynchronous active-low reset.
REQ-006 instr_req_i  input  1  instruction fetch request; held until granted.
REQ-007 instr_addr_i  input  ADDR_WIDTH  fetch byte address.
REQ-008 instr_gnt_o  output  1  fetch request accepted this cycle.
REQ-009 instr_rvalid_o  output  1  instr_rdata_o valid.
REQ-010 instr_rdata_o  output  DATA_WIDTH  fetched word.
REQ-011 data_req_i  input  1  load/store request; held until granted.
REQ-012 data_we_i  input  1  1 = store, 0 = load.
REQ-013 data_be_i  input  DATA_WIDTH/8  store byte enables.
REQ-014 data_addr_i  input  ADDR_WIDTH  load/store byte address.
REQ-015 data_wdata_i  input  DATA_WIDTH  store data.
REQ-016 data_gnt_o  output  1  load/store accepted this cycle.
REQ-017 data_rvalid_o  output  1  data_rdata_o valid (loads only).
REQ-018 data_rdata_o  output  DATA_WIDTH  loaded word.
REQ-019 mem_en_o  output  1  RAM access strobe.
REQ-020 mem_we_o  output  DATA_WIDTH/8  per-byte RAM write enables.
REQ-021 mem_addr_o  output  ADDR_WIDTH  RAM byte address.
REQ-022 mem_wdata_o  output  DATA_WIDTH  RAM write data.
REQ-023 mem_rdata_i  input  DATA_WIDTH  RAM read data, valid exactly one cycle after a read strobe.

Function
REQ-024 Grant decision, request forwarding and gnt outputs are combinational in the same cycle; at most one gnt asserted per cycle.
REQ-025 Arbitration: data port wins when both request, unless the streak counter equals MAX_DATA_STREAK, then instruction wins.
REQ-026 Streak counter: +1 on each data grant while instr_req_i=1, saturating at MAX_DATA_STREAK; cleared on any instruction grant or any cycle with instr_req_i=0.
REQ-027 Granted data access: mem_en_o=1, mem_addr_o=data_addr_i, mem_wdata_o=data_wdata_i, mem_we_o=data_be_i if data_we_i else 0.
REQ-028 Granted instruction access: mem_en_o=1, mem_addr_o=instr_addr_i, mem_we_o=0, mem_wdata_o=0.
REQ-029 No grant: mem_en_o=0, mem_we_o=0, other memory outputs 0.
REQ-030 Response owner register captures OWN_INSTR, OWN_DATA or OWN_NONE each cycle; stores record OWN_NONE.
REQ-031 Cycle after a granted read, the owner's rvalid=1 for exactly one cycle with rdata=mem_rdata_i; the other port's rvalid=0.
REQ-032 rdata outputs are 0 whenever the matching rvalid is 0.
REQ-033 Back-to-back grants allowed every cycle; response N+1 follows response N by one cycle with no bubble.
REQ-034 Simultaneous new grant and pending response in the same cycle are independent; both occur.

Reset
REQ-035 rstn_i low asynchronously clears owner register to OWN_NONE and streak counter to 0; all gnt, rvalid, mem_en_o, mem_we_o deassert and rdata outputs are 0 while reset is held.
REQ-036 A read granted in the cycle before reset assertion produces no rvalid after reset release.
REQ-037 First grant possible in the first rising edge cycle after rstn_i rises.

Structure
REQ-038 Package jedro_1_mem_arb_pkg holds owner_e enum (OWN_NONE, OWN_INSTR, OWN_DATA) and streak counter width derivation.
REQ-039 Single flat module; no sub-module.

Verification
REQ-040 Instr only: fetch 0x0000_0010, RAM word 0xDEAD_BEEF -> instr_gnt_o same cycle, instr_rvalid_o next cycle with 0xDEAD_BEEF, data_rvalid_o=0.
REQ-041 Simultaneous requests, data load 0x100 and fetch 0x4 -> data granted first, instruction granted next cycle, rvalids in same order on consecutive cycles.
REQ-042 Data requests continuously with instr requesting, MAX_DATA_STREAK=4 -> 4 data grants, 1 instr grant, pattern repeats.
REQ-043 Store be=4'b0001 data 0x0000_00FF to 0x20 -> mem_we_o=4'b0001, no rvalid; following load of 0x20 returns 0xFF in byte 0.
REQ-044 Reset asserted the cycle after a read grant -> no rvalid ever appears for it; all outputs 0 during reset.

Source files
------------

// File: rtl/jedro_1_mem_arb_pkg.sv
// Shared definitions for the jedro_1 memory arbiter: response-owner
// encoding and the width rule for the data-streak counter.
package jedro_1_mem_arb_pkg;

    // Which port owns the read response returning in the next cycle.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    // Bits needed to count 0..max_streak inclusive (at least one bit).
    function automatic int streak_width(input int max_streak);
        if (max_streak < 1) begin
            return 1;
        end
        return $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/jedro_1_mem_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single-port RAM
// with one cycle of read latency.
//
// Handshake: a port raises req and holds it (with its address/data
// stable) until it sees gnt in the same cycle; gnt is combinational
// from req. A granted read returns rvalid for exactly one cycle, in
// the cycle after the grant, with rdata taken straight from the RAM.
// Stores are fire-and-forget and never produce rvalid.
//
// Arbitration favours the data port, but after MAX_DATA_STREAK
// consecutive data grants while the instruction port is waiting, the
// instruction port is served once so fetch can never starve.
module jedro_1_mem_arbiter
    import jedro_1_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,

    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,

    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,

    output logic                    mem_en_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int                  STREAK_W   = streak_width(MAX_DATA_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    owner_e              owner_q;
    owner_e              owner_d;
    logic                streak_full;
    logic                grant_data;
    logic                grant_instr;

    // Grant decision: data wins unless fetch is waiting and the streak is used up.
    // Grants are held off while reset is asserted.
    always_comb begin
        streak_full = (streak_q == STREAK_MAX);
        grant_data  = rstn_i && data_req_i && !(instr_req_i && streak_full);
        grant_instr = rstn_i && instr_req_i && !grant_data;
        instr_gnt_o = grant_instr;
        data_gnt_o  = grant_data;
    end

    // Forward the winning request to the RAM; everything is zero when idle.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (grant_data) begin
            mem_en_o    = 1'b1;
            mem_we_o    = data_we_i ? data_be_i : '0;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end else if (grant_instr) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = instr_addr_i;
        end
    end

    // Next streak count and next response owner.
    always_comb begin
        streak_d = streak_q;
        if (!instr_req_i || grant_instr) begin
            streak_d = '0;
        end else if (grant_data && !streak_full) begin
            streak_d = streak_q + STREAK_ONE;
        end

        owner_d = OWN_NONE;
        if (grant_instr) begin
            owner_d = OWN_INSTR;
        end else if (grant_data && !data_we_i) begin
            owner_d = OWN_DATA;
        end
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            streak_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            streak_q <= streak_d;
            owner_q  <= owner_d;
        end
    end

    // Steer the RAM read data to the owning port; rdata is zero when not valid.
    always_comb begin
        instr_rvalid_o = (owner_q == OWN_INSTR);
        data_rvalid_o  = (owner_q == OWN_DATA);
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
        data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Directed bench for jedro_1_mem_arbiter. The driver applies one input
// vector per cycle and pushes the hand-computed grant (same cycle) and
// read response (next cycle) into expected queues; a monitor on the
// falling edge pops and compares whenever the DUT shows gnt or rvalid.
module tb_jedro_1_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // {cycle[15:0], port[1:0], en, we[3:0], addr[31:0], wdata[31:0]}
    logic [86:0] gnt_q[$];
    // {cycle[15:0], port[1:0], rdata[31:0]}
    logic [49:0] rsp_q[$];
    logic [86:0] g_act;
    logic [49:0] r_act;

    logic [31:0] ram [0:255];

    jedro_1_mem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_DATA_STREAK(4)
    ) dut (
        .clk_i(clk_i),
        .rstn_i(rstn_i),
        .instr_req_i(instr_req_i),
        .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i),
        .data_we_i(data_we_i),
        .data_be_i(data_be_i),
        .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o),
        .mem_en_o(mem_en_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- RAM behaviour: byte writes, 1-cycle read ----------------
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we_o[b]) ram[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
            mem_rdata_i <= ram[mem_addr_o[9:2]];
        end else begin
            mem_rdata_i <= 32'hBAD0_0000 ^ 32'($urandom_range(0, 255));
        end
    end

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        check({name, "_ctl"}, {instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o,
                               mem_en_o, mem_we_o, instr_rdata_o, data_rdata_o}, '0);
        check({name, "_bus"}, {mem_addr_o, mem_wdata_o}, '0);
    endtask

    // ---------------- driver ----------------
    // eg: expected grant (0 none, 1 instr, 2 data) in this cycle.
    // er/erd: expected response port and word in the next cycle.
    task automatic step(input logic ireq, input logic [31:0] iaddr,
                        input logic dreq, input logic dwe, input logic [3:0] dbe,
                        input logic [31:0] daddr, input logic [31:0] dwd,
                        input logic [1:0] eg, input logic [1:0] er, input logic [31:0] erd);
        instr_req_i  = ireq;
        instr_addr_i = iaddr;
        data_req_i   = dreq;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_addr_i  = daddr;
        data_wdata_i = dwd;
        if (eg == 2'd1) gnt_q.push_back({16'(cyc), 2'd1, 1'b1, 4'h0, iaddr, 32'h0});
        if (eg == 2'd2) gnt_q.push_back({16'(cyc), 2'd2, 1'b1, (dwe ? dbe : 4'h0), daddr, dwd});
        if (er != 2'd0) rsp_q.push_back({16'(cyc + 1), er, erd});
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd0, 2'd0, 32'h0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (instr_gnt_o && data_gnt_o) check("gnt_onehot", 2'b11, 2'b01);
            if (instr_gnt_o || data_gnt_o) begin
                g_act = {16'(cyc), data_gnt_o, instr_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o};
                if (gnt_q.size() == 0) check("gnt_unexpected", g_act, '0);
                else check("gnt", g_act, gnt_q.pop_front());
            end else begin
                check("idle_mem", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}, '0);
            end
            if (instr_rvalid_o || data_rvalid_o) begin
                r_act = {16'(cyc), data_rvalid_o, instr_rvalid_o,
                         (instr_rvalid_o ? instr_rdata_o : data_rdata_o)};
                if (rsp_q.size() == 0) check("rsp_unexpected", r_act, '0);
                else check("rsp", r_act, rsp_q.pop_front());
            end
            if (!instr_rvalid_o) check("instr_rdata_zero", instr_rdata_o, '0);
            if (!data_rvalid_o)  check("data_rdata_zero", data_rdata_o, '0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[1]  = 32'hA5A5_0004;   // 0x004
        ram[4]  = 32'hDEAD_BEEF;   // 0x010
        ram[8]  = 32'h1234_5600;   // 0x020
        ram[64] = 32'h1122_3344;   // 0x100

        rstn_i = 1'b0;
        instr_req_i = 1'b0; instr_addr_i = '0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0;
        data_addr_i = '0; data_wdata_i = '0;

        repeat (2) begin
            @(negedge clk_i);
            chk_quiet("reset");
        end
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;

        // Instruction fetch alone.
        step(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd1, 2'd1, 32'hDEAD_BEEF);
        idle();

        // Both request: data first, then fetch; responses on consecutive cycles.
        step(1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 2'd2, 2'd2, 32'h1122_3344);
        step(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0, 2'd1, 2'd1, 32'hA5A5_0004);
        idle();

        // Continuous contention: D D D D I, twice.
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                step(1'b1, 32'h4, 1'b1, 1'b0, 4'hF, 32'h100, 32'h55, 2'd1, 2'd1, 32'hA5A5_0004);
            else
                step(1'b1, 32'h4, 1'b1, 1'b0, 4'hF, 32'h100, 32'h55, 2'd2, 2'd2, 32'h1122_3344);
        end

        // Streak saturated, then fetch drops: data still wins and streak clears.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 2'd2, 2'd2, 32'h1122_3344);
        step(1'b0, 32'h4, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 2'd2, 2'd2, 32'h1122_3344);
        step(1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 2'd2, 2'd2, 32'h1122_3344);
        step(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0, 2'd1, 2'd1, 32'hA5A5_0004);
        idle();

        // Byte store then read-back.
        step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0001, 32'h20, 32'h0000_00FF, 2'd2, 2'd0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF,    32'h20, 32'h0,         2'd2, 2'd2, 32'h1234_56FF);
        idle();

        // Reset right after a read grant: its response must vanish.
        step(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd1, 2'd0, 32'h0);
        rstn_i      = 1'b0;
        instr_req_i = 1'b1;
        data_req_i  = 1'b1;
        data_we_i   = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            chk_quiet("rst_hold");
        end
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;

        // Grant available in the very first cycle out of reset.
        step(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd1, 2'd1, 32'hDEAD_BEEF);
        step(1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 2'd2, 2'd2, 32'h1122_3344);
        step(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0, 2'd1, 2'd1, 32'hA5A5_0004);
        idle();
        idle();

        check("gnt_q_drained", 128'(gnt_q.size()), '0);
        check("rsp_q_drained", 128'(rsp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
